tcam_lookup_ctrl: RTL

Command front-end that sits directly upstream of the 16-entry TCAM and also drains its match outputs. It accepts write and search commands over a valid/ready handshake, drives the TCAM data/mask/address/write_readN inputs from registers, and captures the TCAM's `found_address`/`hit` at the correct cycle. It tracks which entries have been written and returns search results through a 4-deep response FIFO with backpressure.

---
 rtl/tcam_lookup_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/tcam_lookup_ctrl.sv
// Command front-end for a 16-entry TCAM: issues writes/searches,
// filters unwritten-entry hits and queues search responses.
module tcam_lookup_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_key,
  input  logic [15:0] cmd_mask,
  input  logic [3:0]  cmd_addr,
  output logic [15:0] tcam_data,
  output logic [15:0] tcam_mask,
  output logic [3:0]  tcam_addr,
  output logic        tcam_write_readN,
  input  logic [3:0]  tcam_found_address,
  input  logic        tcam_hit,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [3:0]  rsp_addr,
  output logic [15:0] valid_map,
  output logic [7:0]  hit_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic [CW:0]    credit;
  logic           s1;
  logic           s2;
  logic [DEPTH-1:0] fifo_hit;
  logic [3:0]     fifo_addr [DEPTH];
  logic           accept;
  logic           push;
  logic           pop;
  logic           push_hit;
  logic [3:0]     push_addr;

  // In-flight searches reserve a FIFO slot so no response can be dropped
  assign credit = {1'b0, count}
                + {{CW{1'b0}}, s1}
                + {{CW{1'b0}}, s2};
  assign cmd_ready = credit < (CW+1)'(DEPTH);
  assign accept    = cmd_valid & cmd_ready;

  assign push      = s2;
  assign pop       = rsp_valid & rsp_ready;
  assign push_hit  = tcam_hit & valid_map[tcam_found_address];
  assign push_addr = push_hit ? tcam_found_address : 4'd0;

  assign rsp_valid = count != '0;
  assign rsp_hit   = rsp_valid & fifo_hit[rptr];
  assign rsp_addr  = rsp_valid ? fifo_addr[rptr] : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcam_data        <= '0;
      tcam_mask        <= '0;
      tcam_addr        <= '0;
      tcam_write_readN <= 1'b0;
      valid_map        <= '0;
      s1               <= 1'b0;
      s2               <= 1'b0;
    end else begin
      tcam_write_readN <= 1'b0;
      s1 <= accept & ~cmd_write;
      s2 <= s1;
      if (accept) begin
        tcam_data        <= cmd_key;
        tcam_write_readN <= cmd_write;
        if (cmd_write) begin
          tcam_mask           <= cmd_mask;
          tcam_addr           <= cmd_addr;
          valid_map[cmd_addr] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      fifo_hit  <= '0;
      hit_count <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_addr[i] <= '0;
    end else begin
      if (push) begin
        fifo_hit[wptr]  <= push_hit;
        fifo_addr[wptr] <= push_addr;
        wptr            <= wptr + 1'b1;
        if (push_hit && hit_count != 8'hFF)
          hit_count <= hit_count + 8'd1;
      end
      if (pop) rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
